// File: rtl/menu_compositor.sv
// Menu overlay compositor: lowest-index opaque sprite layer wins (with blink gating),
// plus a three-state key FSM driving a wrapping cursor and a one-cycle confirm strobe.
module menu_compositor #(
    parameter int                    NUM_LAYERS = 8,
    parameter int                    NUM_ITEMS  = 2,
    parameter int                    BLINK_BITS = 21,
    parameter logic [NUM_LAYERS-1:0] BLINK_MASK = NUM_LAYERS'(8'b0000_0110),
    parameter logic [11:0]           BG_COLOR   = 12'h000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_LAYERS*16-1:0]   layer_color,
    input  logic [NUM_LAYERS-1:0]      layer_valid,
    input  logic                       key_up,
    input  logic                       key_down,
    input  logic                       key_sel,
    output logic [2:0]                 cursor,
    output logic                       sel_pulse,
    output logic                       blink,
    output logic [11:0]                color
);

    typedef enum logic [1:0] {BROWSE, CONFIRM, HOLD} state_t;

    localparam logic [2:0] LAST_ITEM = 3'(NUM_ITEMS - 1);

    logic [BLINK_BITS-1:0] cnt_q;
    logic                  up_q, dn_q, sel_q;
    state_t                state_q;
    logic [2:0]            cursor_q;
    logic                  sel_pulse_q;
    logic [11:0]           color_q, color_d;
    logic [NUM_LAYERS-1:0] disp;
    logic [NUM_LAYERS-1:0] unused_nib;
    logic                  up_e, dn_e, sel_e;

    assign blink     = cnt_q[BLINK_BITS-1];
    assign cursor    = cursor_q;
    assign sel_pulse = sel_pulse_q;
    assign color     = color_q;

    assign up_e  = key_up   & ~up_q;
    assign dn_e  = key_down & ~dn_q;
    assign sel_e = key_sel  & ~sel_q;

    // Blinking layers are hidden during the low blink phase; scan downward so layer 0 wins.
    always_comb begin
        disp    = layer_valid & ~(BLINK_MASK & {NUM_LAYERS{~blink}});
        color_d = BG_COLOR;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (disp[i]) color_d = layer_color[16*i+4 +: 12];
        end
    end

    always_comb begin
        unused_nib = '0;
        for (int i = 0; i < NUM_LAYERS; i++) unused_nib[i] = ^layer_color[16*i +: 4];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
            sel_q   <= 1'b0;
            color_q <= BG_COLOR;
        end else begin
            cnt_q   <= cnt_q + 1'b1;
            up_q    <= key_up;
            dn_q    <= key_down;
            sel_q   <= key_sel;
            color_q <= color_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= BROWSE;
            cursor_q    <= 3'd0;
            sel_pulse_q <= 1'b0;
        end else begin
            case (state_q)
                BROWSE: begin
                    if (sel_e) begin
                        state_q     <= CONFIRM;
                        sel_pulse_q <= 1'b1;
                    end else if (up_e && !dn_e) begin
                        cursor_q <= (cursor_q == 3'd0) ? LAST_ITEM : cursor_q - 3'd1;
                    end else if (dn_e && !up_e) begin
                        cursor_q <= (cursor_q == LAST_ITEM) ? 3'd0 : cursor_q + 3'd1;
                    end
                end
                CONFIRM: begin
                    state_q     <= HOLD;
                    sel_pulse_q <= 1'b0;
                end
                HOLD: begin
                    if (!key_sel) state_q <= BROWSE;
                end
                default: begin
                    state_q     <= BROWSE;
                    sel_pulse_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_menu_compositor.sv
// Scoreboard bench: a cycle-level reference model pushes expected outputs at each rising
// edge; a monitor pops and compares at the falling edge.
module tb_menu_compositor;
    localparam int          NL = 8;
    localparam int          NI = 3;
    localparam int          BB = 4;
    localparam logic [7:0]  BM = 8'b0000_0110;
    localparam logic [11:0] BG = 12'h5A3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NL*16-1:0]  layer_color;
    logic [NL-1:0]     layer_valid;
    logic              key_up, key_down, key_sel;
    logic [2:0]        cursor;
    logic              sel_pulse, blink;
    logic [11:0]       color;

    always #5 clk = ~clk;

    menu_compositor #(
        .NUM_LAYERS(NL), .NUM_ITEMS(NI), .BLINK_BITS(BB), .BLINK_MASK(BM), .BG_COLOR(BG)
    ) dut (
        .clk(clk), .rst(rst), .layer_color(layer_color), .layer_valid(layer_valid),
        .key_up(key_up), .key_down(key_down), .key_sel(key_sel),
        .cursor(cursor), .sel_pulse(sel_pulse), .blink(blink), .color(color)
    );

    typedef struct packed {
        logic [11:0] col;
        logic [2:0]  cur;
        logic        pulse;
        logic        blink;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   pulses = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // Reference model: 0=browse, 1=confirm, 2=hold.
    int mode, cur, cnt;
    bit pu, pd, ps;

    function automatic logic [11:0] ref_color(input logic [NL*16-1:0] c, input logic [NL-1:0] v,
                                              input bit bl);
        logic [7:0] m;
        m = BM;
        for (int i = 0; i < NL; i++)
            if (v[i] && !(m[i] && !bl)) return c[16*i+4 +: 12];
        return BG;
    endfunction

    always begin
        exp_t e;
        bit   eu, ed, es, bl_now;
        @(posedge clk);
        if (rst) begin
            cnt = 0; mode = 0; cur = 0; pu = 0; pd = 0; ps = 0;
            e.col = BG;
        end else begin
            bl_now = ((cnt >> (BB - 1)) & 1) != 0;
            e.col  = ref_color(layer_color, layer_valid, bl_now);
            eu = key_up && !pu;
            ed = key_down && !pd;
            es = key_sel && !ps;
            case (mode)
                0: if (es) mode = 1;
                   else if (eu && !ed) cur = (cur + NI - 1) % NI;
                   else if (ed && !eu) cur = (cur + 1) % NI;
                1: mode = 2;
                default: if (!key_sel) mode = 0;
            endcase
            cnt = (cnt + 1) % (1 << BB);
            pu = key_up; pd = key_down; ps = key_sel;
        end
        e.cur   = 3'(cur);
        e.pulse = (mode == 1);
        e.blink = ((cnt >> (BB - 1)) & 1) != 0;
        q.push_back(e);
    end

    always begin
        exp_t e;
        @(negedge clk);
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("color", 32'(color), 32'(e.col));
            chk("cursor", 32'(cursor), 32'(e.cur));
            chk("sel_pulse", 32'(sel_pulse), 32'(e.pulse));
            chk("blink", 32'(blink), 32'(e.blink));
        end
        if (sel_pulse === 1'b1) pulses++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic keys(input bit u, input bit d, input bit s);
        key_up = u; key_down = d; key_sel = s;
        cyc(2);
        key_up = 0; key_down = 0; key_sel = 0;
        cyc(3);
    endtask

    // Caller must be at a falling edge; reset lands asynchronously 1 time unit later.
    task automatic async_rst(input int hold);
        #1 rst = 1'b1;
        #1;
        chk("rst_cursor", 32'(cursor), 32'd0);
        chk("rst_pulse", 32'(sel_pulse), 32'd0);
        chk("rst_blink", 32'(blink), 32'd0);
        chk("rst_color", 32'(color), 32'(BG));
        key_up = 0; key_down = 0; key_sel = 0;
        cyc(hold);
        rst = 1'b0;
    endtask

    initial begin
        int p0;
        rst = 1'b1;
        layer_color = '0; layer_valid = '0;
        key_up = 0; key_down = 0; key_sel = 0;
        cyc(3);
        rst = 1'b0;
        cyc(2);

        // Priority: layers 5 and 7 opaque, layer 5 wins.
        for (int w = 0; w < NL / 2; w++) layer_color[32*w +: 32] = $urandom;
        layer_color[16*5 +: 16] = 16'hF0F0;
        layer_valid = 8'b1010_0000;
        cyc(2);
        chk("prio_color", 32'(color), 32'h0F0F);
        layer_valid = '0;
        cyc(2);
        chk("prio_bg", 32'(color), 32'(BG));

        // Blink mask on layer 1, across both blink phases.
        layer_valid = 8'b0000_0010;
        cyc(20);
        layer_valid = '0;
        cyc(1);

        // Cursor wrap.
        keys(1, 0, 0);
        chk("wrap_up", 32'(cursor), 32'd2);
        keys(0, 1, 0); keys(0, 1, 0); keys(0, 1, 0);
        chk("wrap_down", 32'(cursor), 32'd2);

        // Confirm with sel held 10 cycles and downs ignored meanwhile.
        p0 = pulses;
        key_sel = 1;
        cyc(2);
        for (int i = 0; i < 4; i++) begin
            key_down = 1; cyc(1); key_down = 0; cyc(1);
        end
        key_sel = 0;
        cyc(3);
        chk("confirm_pulses", 32'(pulses - p0), 32'd1);
        chk("confirm_cursor", 32'(cursor), 32'd2);

        // Simultaneous edges.
        keys(1, 1, 0);
        chk("updown_cursor", 32'(cursor), 32'd2);
        p0 = pulses;
        keys(0, 1, 1);
        chk("seldown_cursor", 32'(cursor), 32'd2);
        chk("seldown_pulses", 32'(pulses - p0), 32'd1);

        // Reset while in HOLD with cursor=1, then resume browsing.
        keys(0, 1, 0); keys(0, 1, 0);
        chk("pre_rst_cursor", 32'(cursor), 32'd1);
        key_sel = 1;
        cyc(3);
        async_rst(2);
        cyc(2);
        keys(0, 1, 0);
        chk("post_rst_cursor", 32'(cursor), 32'd1);

        // Reset mid-CONFIRM.
        key_sel = 1;
        cyc(1);
        chk("confirm_before_rst", 32'(sel_pulse), 32'd1);
        async_rst(1);
        cyc(3);

        // Randomized traffic with occasional asynchronous resets.
        for (int n = 0; n < 1500; n++) begin
            for (int w = 0; w < NL / 2; w++) layer_color[32*w +: 32] = $urandom;
            layer_valid = ($urandom_range(3) == 0) ? '0 : NL'($urandom & $urandom);
            if ($urandom_range(3) == 0) key_up = ~key_up;
            if ($urandom_range(3) == 0) key_down = ~key_down;
            if ($urandom_range(5) == 0) key_sel = ~key_sel;
            if ($urandom_range(199) == 0) async_rst(1 + $urandom_range(2));
            else cyc(1);
        end

        layer_valid = '0;
        key_up = 0; key_down = 0; key_sel = 0;
        cyc(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
